multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/rv32i_pkg.sv | 60 ++++++
 rtl/branch_resolve.sv | 29 ++
 rtl/multicycle_controller.sv | 172 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds opcodes, FSM state encoding and datapath mux select encodings.
package rv32i_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEMADR    = 4'd2,
      S_MEMREAD   = 4'd3,
      S_MEMWB     = 4'd4,
      S_MEMWRITE  = 4'd5,
      S_EXECR     = 4'd6,
      S_EXECI     = 4'd7,
      S_ALUWB     = 4'd8,
      S_JALR_CALC = 4'd9,
      S_JAL       = 4'd10,
      S_BRANCH    = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   localparam logic [1:0] IMM_I = 2'b00;
   localparam logic [1:0] IMM_S = 2'b01;
   localparam logic [1:0] IMM_B = 2'b10;
   localparam logic [1:0] IMM_J = 2'b11;

   localparam logic [1:0] RES_ALUOUT    = 2'b00;
   localparam logic [1:0] RES_MEMDATA   = 2'b01;
   localparam logic [1:0] RES_ALURESULT = 2'b10;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RS1   = 2'b10;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   // Immediate format the decode stage should present for a given opcode.
   function automatic logic [1:0] imm_for_op(input logic [6:0] op);
      case (op)
         OP_STORE:  return IMM_S;
         OP_BRANCH: return IMM_B;
         OP_JAL:    return IMM_J;
         default:   return IMM_I;
      endcase
   endfunction

endpackage

// File: rtl/branch_resolve.sv
// Branch condition evaluation from func3 and the ALU compare flags.
// 'bad' marks the two func3 codes that are not valid branch types.
module branch_resolve
   import rv32i_pkg::*;
(
   input  logic [2:0] func3,
   input  logic       Zero,
   input  logic       Lt,
   input  logic       Ltu,
   output logic       taken,
   output logic       bad
);

   // Select the compare flag (or its inverse) chosen by func3.
   always_comb begin
      taken = 1'b0;
      bad   = 1'b0;
      case (func3)
         3'b000:  taken = Zero;
         3'b001:  taken = ~Zero;
         3'b100:  taken = Lt;
         3'b101:  taken = ~Lt;
         3'b110:  taken = Ltu;
         3'b111:  taken = ~Ltu;
         default: bad   = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main control FSM.
// One state per datapath step; memory states stall on MemReady, illegal
// opcodes and branch types park the FSM in TRAP until reset.
module multicycle_controller
   import rv32i_pkg::*;
#(
   parameter int MEM_WAIT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] func3,
   input  logic       Zero,
   input  logic       Lt,
   input  logic       Ltu,
   input  logic       MemReady,
   output logic       MemReq,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       RegWrite,
   output logic       Illegal,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] ImmSrc
);

   state_t state;
   state_t state_next;
   logic   mem_ready;
   logic   br_taken;
   logic   br_bad;

   assign mem_ready = (MEM_WAIT != 0) ? MemReady : 1'b1;

   branch_resolve u_branch (
      .func3 (func3),
      .Zero  (Zero),
      .Lt    (Lt),
      .Ltu   (Ltu),
      .taken (br_taken),
      .bad   (br_bad)
   );

   // State register; reset wins over any pending transition.
   always_ff @(posedge clk) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   // Sticky illegal flag, raised on entry to TRAP and cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst)                      Illegal <= 1'b0;
      else if (state_next == S_TRAP) Illegal <= 1'b1;
   end

   // Next-state and per-state control outputs; enables are squashed during reset.
   always_comb begin
      state_next = state;
      MemReq     = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RS2;
      ALUOp      = ALUOP_ADD;
      ImmSrc     = IMM_I;
      case (state)
         S_FETCH: begin
            MemReq    = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURESULT;
            if (mem_ready) begin
               IRWrite    = 1'b1;
               PCWrite    = 1'b1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = imm_for_op(op);
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_RTYPE:          state_next = S_EXECR;
               OP_ITYPE:          state_next = S_EXECI;
               OP_JAL:            state_next = S_JAL;
               OP_JALR:           state_next = S_JALR_CALC;
               OP_BRANCH:         state_next = S_BRANCH;
               default:           state_next = S_TRAP;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ImmSrc     = (op == OP_STORE) ? IMM_S : IMM_I;
            state_next = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            MemReq = 1'b1;
            AdrSrc = 1'b1;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc  = RES_MEMDATA;
            RegWrite   = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWRITE: begin
            MemReq   = 1'b1;
            AdrSrc   = 1'b1;
            MemWrite = 1'b1;
            if (mem_ready) state_next = S_FETCH;
         end
         S_EXECR: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_RS2;
            ALUOp      = ALUOP_FUNC;
            state_next = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            ALUOp      = ALUOP_FUNC;
            state_next = S_ALUWB;
         end
         S_ALUWB: begin
            RegWrite   = 1'b1;
            state_next = S_FETCH;
         end
         S_JALR_CALC: begin
            ALUSrcA    = SRCA_RS1;
            ALUSrcB    = SRCB_IMM;
            state_next = S_JAL;
         end
         S_JAL: begin
            ALUSrcA    = SRCA_OLDPC;
            ALUSrcB    = SRCB_FOUR;
            PCWrite    = 1'b1;
            state_next = S_ALUWB;
         end
         S_BRANCH: begin
            ALUSrcA = SRCA_RS1;
            ALUSrcB = SRCB_RS2;
            ALUOp   = ALUOP_SUB;
            ImmSrc  = IMM_B;
            if (br_bad) begin
               state_next = S_TRAP;
            end else begin
               PCWrite    = br_taken;
               state_next = S_FETCH;
            end
         end
         S_TRAP:  state_next = S_TRAP;
         default: state_next = S_FETCH;
      endcase
      if (rst) begin
         MemReq   = 1'b0;
         MemWrite = 1'b0;
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction is expanded
// into its expected per-cycle output sequence (with random memory waits) and
// the DUT is compared against it every cycle, plus literal latency/count pins.
module tb_multicycle_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] func3 = 3'd0;
   logic       Zero = 1'b0, Lt = 1'b0, Ltu = 1'b0;
   logic       MemReady = 1'b0;
   logic       MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, Illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

   multicycle_controller #(.MEM_WAIT(1)) dut (
      .clk(clk), .rst(rst), .op(op), .func3(func3),
      .Zero(Zero), .Lt(Lt), .Ltu(Ltu), .MemReady(MemReady),
      .MemReq(MemReq), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .PCWrite(PCWrite), .RegWrite(RegWrite), .Illegal(Illegal),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .ImmSrc(ImmSrc)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
   localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, JR = 7'b1100111;
   localparam logic [6:0] BR = 7'b1100011, LUI = 7'b0110111;

   // {MemReq,AdrSrc,MemWrite,IRWrite,PCWrite,RegWrite,Illegal,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc}
   localparam logic [16:0] FULL    = 17'h1FFFF;
   localparam logic [16:0] EN_MASK = 17'h17800;

   int checks = 0, errors = 0;
   int c_cyc, c_mreq, c_rw, c_mw, c_pcw, c_ill;

   logic [16:0] act;
   assign act = {MemReq, AdrSrc, MemWrite, IRWrite, PCWrite, RegWrite, Illegal,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc};

   function automatic logic [16:0] o(input logic mreq, adr, mw, irw, pcw, rw, ill,
                                     input logic [1:0] rs, sa, sb, aop, imm);
      return {mreq, adr, mw, irw, pcw, rw, ill, rs, sa, sb, aop, imm};
   endfunction

   function automatic logic br_taken(input logic [2:0] f3, input logic z, l, lu);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return l;
         3'd5: return !l;
         3'd6: return lu;
         3'd7: return !lu;
         default: return 1'b0;
      endcase
   endfunction

   // One clock: drive inputs, compare at the falling edge, tally observed enables.
   task automatic step(input logic r, input logic ready, input logic [16:0] e,
                       input logic [16:0] m, input string nm);
      rst = r;
      MemReady = ready;
      @(negedge clk);
      checks++;
      if ((act & m) !== (e & m)) begin
         errors++;
         $display("FAIL %s t=%0t actual=%05h required=%05h mask=%05h", nm, $time, act, e, m);
      end
      if (!r) begin
         c_cyc++;
         c_mreq += int'(MemReq);
         c_rw   += int'(RegWrite);
         c_mw   += int'(MemWrite);
         c_pcw  += int'(PCWrite);
         c_ill  += int'(Illegal);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pin(input string nm, input int a, input int req);
      checks++;
      if (a != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, a, req);
      end
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'($urandom % 2), 17'h0, EN_MASK, "reset");
   endtask

   task automatic trap(input int n);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,0,1,0,0,0,0,0), FULL, "trap");
      do_reset(1 + int'($urandom % 2));
   endtask

   // Expand one instruction into its expected cycle sequence and run it.
   task automatic run_instr(input logic [6:0] op_i, input logic [2:0] f3,
                            input logic z, l, lu, input int fw, input int mw,
                            input bit abort, input int trap_n);
      logic [16:0] e;
      logic [1:0]  imm;
      op = op_i; func3 = f3; Zero = z; Lt = l; Ltu = lu;
      c_cyc = 0; c_mreq = 0; c_rw = 0; c_mw = 0; c_pcw = 0; c_ill = 0;
      for (int i = 0; i < fw; i++) step(1'b0, 1'b0, o(1,0,0,0,0,0,0,2,0,2,0,0), FULL, "fetch_stall");
      step(1'b0, 1'b1, o(1,0,0,1,1,0,0,2,0,2,0,0), FULL, "fetch");
      imm = (op_i == SW) ? 2'd1 : (op_i == BR) ? 2'd2 : (op_i == JL) ? 2'd3 : 2'd0;
      step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,0,0,0,1,1,0,imm), FULL, "decode");
      case (op_i)
         LW, SW: begin
            step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,0,0,0,2,1,0,(op_i == SW) ? 2'd1 : 2'd0), FULL, "memadr");
            e = (op_i == SW) ? o(1,1,1,0,0,0,0,0,0,0,0,0) : o(1,1,0,0,0,0,0,0,0,0,0,0);
            for (int i = 0; i < mw; i++) step(1'b0, 1'b0, e, FULL, "mem_stall");
            if (abort) begin
               do_reset(1 + int'($urandom % 2));
               return;
            end
            step(1'b0, 1'b1, e, FULL, "mem_access");
            if (op_i == LW) step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,1,0,1,0,0,0,0), FULL, "memwb");
         end
         RT, IT: begin
            step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,0,0,0,2,(op_i == IT) ? 2'd1 : 2'd0,2,0), FULL, "exec");
            step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,1,0,0,0,0,0,0), FULL, "aluwb");
         end
         JL, JR: begin
            if (op_i == JR) step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,0,0,0,2,1,0,0), FULL, "jalr_calc");
            step(1'b0, 1'($urandom % 2), o(0,0,0,0,1,0,0,0,1,2,0,0), FULL, "jal");
            step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,1,0,0,0,0,0,0), FULL, "aluwb");
         end
         BR: begin
            if (f3 == 3'd2 || f3 == 3'd3) begin
               step(1'b0, 1'($urandom % 2), o(0,0,0,0,0,0,0,0,2,0,1,2), FULL, "branch_bad");
               trap(trap_n);
            end else begin
               step(1'b0, 1'($urandom % 2), o(0,0,0,0,br_taken(f3, z, l, lu),0,0,0,2,0,1,2), FULL, "branch");
            end
         end
         default: trap(trap_n);
      endcase
   endtask

   initial begin
      logic [6:0] rop;
      int         sel, mw;
      bit         ab;
      @(posedge clk);
      #1;
      // Reset held two cycles with MemReady low: enables must stay off.
      step(1'b1, 1'b0, 17'h0, EN_MASK, "reset_init");
      step(1'b1, 1'b0, 17'h0, EN_MASK, "reset_init");

      // lw with three MemReady-low cycles in MEMREAD.
      run_instr(LW, 3'd2, 0, 0, 0, 0, 3, 0, 0);
      pin("lw_cycles", c_cyc, 8);
      pin("lw_memreq_cycles", c_mreq, 5);   // 1 fetch + 4 MEMREAD
      pin("lw_regwrite", c_rw, 1);

      run_instr(SW, 3'd2, 0, 0, 0, 0, 0, 0, 0);
      pin("sw_cycles", c_cyc, 4);
      pin("sw_memwrite", c_mw, 1);
      pin("sw_regwrite", c_rw, 0);

      run_instr(BR, 3'd1, 0, 0, 0, 0, 0, 0, 0);
      pin("bne_taken_cycles", c_cyc, 3);
      pin("bne_taken_pcwrite", c_pcw, 2);    // fetch + branch
      run_instr(BR, 3'd1, 1, 0, 0, 0, 0, 0, 0);
      pin("bne_nt_cycles", c_cyc, 3);
      pin("bne_nt_pcwrite", c_pcw, 1);

      run_instr(LUI, 3'd0, 0, 0, 0, 0, 0, 0, 10);
      pin("trap_illegal_cycles", c_ill, 10);

      run_instr(JR, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      pin("jalr_cycles", c_cyc, 5);
      pin("jalr_pcwrite", c_pcw, 2);
      pin("jalr_regwrite", c_rw, 1);

      run_instr(RT, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      pin("rtype_cycles", c_cyc, 4);
      run_instr(IT, 3'd0, 0, 0, 0, 0, 0, 0, 0);
      pin("itype_cycles", c_cyc, 4);
      run_instr(JL, 3'd0, 0, 0, 0, 2, 0, 0, 0);
      pin("jal_cycles_fetch_wait2", c_cyc, 6);
      run_instr(BR, 3'd3, 0, 0, 0, 0, 0, 0, 3);
      pin("bad_branch_illegal", c_ill, 3);

      // Store aborted by reset mid-stall; the following load is fully checked.
      run_instr(SW, 3'd2, 0, 0, 0, 0, 2, 1, 0);
      pin("abort_sw_memwrite", c_mw, 2);
      run_instr(LW, 3'd2, 0, 0, 0, 0, 0, 0, 0);
      pin("after_abort_lw_cycles", c_cyc, 5);

      // Randomized instruction stream.
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom % 8);
         case (sel)
            0: rop = LW;
            1: rop = SW;
            2: rop = RT;
            3: rop = IT;
            4: rop = JL;
            5: rop = JR;
            6: rop = BR;
            default: begin
               rop = 7'($urandom);
               if (rop inside {LW, SW, RT, IT, JL, JR, BR}) rop = LUI;
            end
         endcase
         mw = int'($urandom % 4);
         ab = ((rop == LW || rop == SW) && ($urandom % 8 == 0));
         if (ab && mw == 0) mw = 1;
         run_instr(rop, 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   int'($urandom % 3), mw, ab, 1 + int'($urandom % 10));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
